// File: rtl/regfile_wb_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_sequencer_if : retire-stream and register write bus    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface regfile_wb_sequencer_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode;
  logic              in_cnd;
  logic [3:0]        in_rA;
  logic [3:0]        in_rB;
  logic [DATA_W-1:0] in_valE;
  logic [DATA_W-1:0] in_valM;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Sequencer side
  modport slave (
    input  in_valid, in_icode, in_cnd, in_rA, in_rB, in_valE, in_valM,
    output in_ready, wr_en, wr_addr, wr_data
  );

  // Memory-stage / register-file side
  modport master (
    output in_valid, in_icode, in_cnd, in_rA, in_rB, in_valE, in_valM,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_sequencer : serialises retiring instructions into      |
// | 0/1/2 register-file writes on a single write port. Rev 1.0        |
// +------------------------------------------------------------------+
module regfile_wb_sequencer #(
  parameter int         DATA_W = 64,
  parameter int         CNT_W  = 16,
  parameter logic [3:0] SP_IDX = 4'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_sequencer_if.slave bus,
  output logic                busy_o,
  output logic                halted_o,
  output logic                bad_icode_o,
  output logic [CNT_W-1:0]    retired_cnt_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;

  localparam logic [3:0] I_HALT  = 4'd0;
  localparam logic [3:0] I_NOP   = 4'd1;
  localparam logic [3:0] I_CMOV  = 4'd2;
  localparam logic [3:0] I_IRMOV = 4'd3;
  localparam logic [3:0] I_RMMOV = 4'd4;
  localparam logic [3:0] I_MRMOV = 4'd5;
  localparam logic [3:0] I_OP    = 4'd6;
  localparam logic [3:0] I_JXX   = 4'd7;
  localparam logic [3:0] I_CALL  = 4'd8;
  localparam logic [3:0] I_RET   = 4'd9;
  localparam logic [3:0] I_PUSH  = 4'd10;
  localparam logic [3:0] I_POP   = 4'd11;

  localparam logic [3:0] R_NONE  = 4'hF;

  logic [1:0]        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [3:0]        sec_addr_q, sec_addr_d;
  logic [DATA_W-1:0] sec_data_q, sec_data_d;
  logic              halted_q, halted_d;
  logic              bad_q, bad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              w_accept;
  logic [3:0]        w_tgt;
  logic [DATA_W-1:0] w_data;
  logic              w_second;
  logic              w_halt;
  logic              w_bad;
  logic              w_wr;

  assign bus.in_ready = rst_n & ~halted_q & (state_q != S_SECOND);
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Decode the first write target; R_NONE means no first write.
  always_comb begin
    w_tgt    = R_NONE;
    w_data   = bus.in_valE;
    w_second = 1'b0;
    w_halt   = 1'b0;
    w_bad    = 1'b0;
    case (bus.in_icode)
      I_HALT:                w_halt = 1'b1;
      I_NOP, I_RMMOV, I_JXX: w_tgt  = R_NONE;
      I_CMOV: begin
        if (bus.in_cnd) w_tgt = bus.in_rB;
      end
      I_IRMOV, I_OP:         w_tgt  = bus.in_rB;
      I_MRMOV: begin
        w_tgt  = bus.in_rA;
        w_data = bus.in_valM;
      end
      I_CALL, I_RET, I_PUSH: w_tgt  = SP_IDX;
      I_POP: begin
        w_tgt    = SP_IDX;
        w_second = (bus.in_rA != R_NONE);
      end
      default:               w_bad  = 1'b1;
    endcase
  end

  assign w_wr = (w_tgt != R_NONE);

  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    sec_addr_d = sec_addr_q;
    sec_data_d = sec_data_q;
    if (state_q == S_SECOND) begin
      wr_en_d   = 1'b1;
      wr_addr_d = sec_addr_q;
      wr_data_d = sec_data_q;
      state_d   = S_ISSUE;
    end else if (w_accept) begin
      wr_en_d = w_wr;
      if (w_wr) begin
        wr_addr_d = w_tgt;
        wr_data_d = w_data;
      end
      // popq's memory result is captured now; it issues one cycle later.
      if (w_second) begin
        sec_addr_d = bus.in_rA;
        sec_data_d = bus.in_valM;
        state_d    = S_SECOND;
      end else begin
        state_d    = S_ISSUE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  assign halted_d = halted_q | (w_accept & w_halt);
  assign bad_d    = w_accept & w_bad;
  assign cnt_d    = cnt_q + CNT_W'(w_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= '0;
      sec_addr_q <= 4'd0;
      sec_data_q <= '0;
      halted_q   <= 1'b0;
      bad_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      sec_addr_q <= sec_addr_d;
      sec_data_q <= sec_data_d;
      halted_q   <= halted_d;
      bad_q      <= bad_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy_o       = wr_en_q | (state_q == S_SECOND);
  assign halted_o     = halted_q;
  assign bad_icode_o  = bad_q;
  assign retired_cnt_o = cnt_q;

endmodule
`default_nettype wire
